// File: rtl/umult_pkg.sv
// Shared types and helpers for the round-robin multiplier scheduler.
package umult_pkg;

    localparam int W_DEF = 64;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Index width for n items, never narrower than one bit.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'd1 << i) < unsigned'(n)) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first asserted request at or after ptr wins.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx
);

    // Scan upward from ptr with wrap; only the first hit is granted
    always_comb begin
        logic found_s;
        int   idx_s;
        gnt     = '0;
        gnt_idx = '0;
        found_s = 1'b0;
        idx_s   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx_s = (int'(ptr) + k) % NREQ;
            if (!found_s && req[idx_s]) begin
                gnt[idx_s] = 1'b1;
                gnt_idx    = IDW'(idx_s);
                found_s    = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/umult_rr_sched.sv
// Shares one external combinational multiplier among NREQ requesters, one operation at a time,
// allowing MUL_CYC cycles for the product to settle before capturing it.
module umult_rr_sched
    import umult_pkg::*;
#(
    parameter int  NREQ    = 4,
    parameter int  W       = W_DEF,
    parameter int  MUL_CYC = 2,
    localparam int IDW     = clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [W-1:0]      mul_a,
    output logic [W-1:0]      mul_b,
    input  logic [2*W-1:0]    mul_p,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [2*W-1:0]    rsp_p
);

    state_t          state_r;
    state_t          state_nxt_s;
    logic [IDW-1:0]  rr_ptr_r;
    logic [IDW-1:0]  id_r;
    logic [IDW-1:0]  gnt_idx_s;
    logic [3:0]      cnt_r;
    logic [NREQ-1:0] gnt_s;
    logic [W-1:0]    sel_a_s;
    logic [W-1:0]    sel_b_s;
    logic            grant_s;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr_r),
        .gnt     (gnt_s),
        .gnt_idx (gnt_idx_s)
    );

    // AND-OR select of the winner's operands (gnt_s is one-hot or zero)
    always_comb begin
        sel_a_s = '0;
        sel_b_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            sel_a_s = sel_a_s | (req_a[i*W +: W] & {W{gnt_s[i]}});
            sel_b_s = sel_b_s | (req_b[i*W +: W] & {W{gnt_s[i]}});
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state and the accept strobe, which is only offered while idle
    always_comb begin
        state_nxt_s = state_r;
        req_ready   = '0;
        grant_s     = 1'b0;
        case (state_r)
            S_IDLE: begin
                req_ready = gnt_s;
                grant_s   = |gnt_s;
                if (grant_s) begin
                    state_nxt_s = S_WAIT;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_nxt_s = S_RESP;
                end else begin
                    state_nxt_s = S_WAIT;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_RESP;
                end
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Operand launch, settle countdown and product capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_a     <= '0;
            mul_b     <= '0;
            id_r      <= '0;
            rr_ptr_r  <= '0;
            cnt_r     <= 4'd0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_p     <= '0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (grant_s) begin
                        mul_a    <= sel_a_s;
                        mul_b    <= sel_b_s;
                        id_r     <= gnt_idx_s;
                        rr_ptr_r <= (gnt_idx_s == IDW'(NREQ - 1)) ? '0 : gnt_idx_s + IDW'(1);
                        cnt_r    <= 4'(MUL_CYC - 1);
                    end else begin
                        rr_ptr_r <= rr_ptr_r;
                    end
                end
                S_WAIT: begin
                    if (cnt_r == 4'd0) begin
                        rsp_p     <= mul_p;
                        rsp_id    <= id_r;
                        rsp_valid <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end else begin
                        rsp_valid <= 1'b1;
                    end
                end
                default: rsp_valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_umult_rr_sched.sv
// Bench for umult_rr_sched: transaction-level model checked every cycle, plus directed literal checks.
module tb_umult_rr_sched;

    localparam int NREQ    = 4;
    localparam int W       = 64;
    localparam int MUL_CYC = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a = '0;
    logic [NREQ*W-1:0] req_b = '0;
    logic [W-1:0]      mul_a;
    logic [W-1:0]      mul_b;
    logic [2*W-1:0]    mul_p;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [1:0]        rsp_id;
    logic [2*W-1:0]    rsp_p;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // The shared multiplier lives outside the scheduler
    assign mul_p = {64'd0, mul_a} * {64'd0, mul_b};

    umult_rr_sched #(.NREQ(NREQ), .W(W), .MUL_CYC(MUL_CYC)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_p(rsp_p)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int first_from(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    // Model: one job at a time; its result is visible MUL_CYC edges after the grant edge
    // and stays visible until accepted.
    int          m_ptr  = 0;
    int          m_age  = 0;
    int          m_id   = 0;
    bit          m_busy = 1'b0;
    logic [63:0] m_a    = '0;
    logic [63:0] m_b    = '0;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_ptr = 0; m_age = 0; m_id = 0; m_busy = 1'b0; m_a = '0; m_b = '0;
        end else if (!m_busy) begin
            int g;
            g = first_from(req_valid, m_ptr);
            if (g >= 0) begin
                m_busy = 1'b1;
                m_age  = 0;
                m_id   = g;
                m_a    = req_a[g*W +: W];
                m_b    = req_b[g*W +: W];
                m_ptr  = (g + 1) % NREQ;
            end
        end else if (m_age >= MUL_CYC) begin
            if (rsp_ready) m_busy = 1'b0;
        end else begin
            m_age++;
        end
    end

    initial forever begin
        @(negedge clk);
        begin
            int              g;
            logic [NREQ-1:0] exp_rdy;
            bit              exp_vld;
            exp_rdy = '0;
            if (!m_busy) begin
                g = first_from(req_valid, m_ptr);
                if (g >= 0) exp_rdy[g] = 1'b1;
            end
            exp_vld = m_busy && (m_age >= MUL_CYC);
            check("req_ready", req_ready, exp_rdy);
            check("rsp_valid", rsp_valid, exp_vld);
            check("mul_a", mul_a, m_a);
            check("mul_b", mul_b, m_b);
            if (exp_vld) begin
                check("rsp_id", rsp_id, m_id);
                check("rsp_p", rsp_p, {64'd0, m_a} * {64'd0, m_b});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation from requester idx alone and collect its response.
    task automatic op(input int idx, input logic [63:0] a, input logic [63:0] b,
                      output int lat, output logic [127:0] p, output int id);
        int              n;
        logic [NREQ-1:0] oh;
        req_a[idx*W +: W] = a;
        req_b[idx*W +: W] = b;
        req_valid = '0;
        req_valid[idx] = 1'b1;
        rsp_ready = 1'b1;
        oh = '0;
        oh[idx] = 1'b1;
        n = 0;
        #1;
        while (!req_ready[idx] && n < 50) begin tick(); n++; end
        check("op_grant", req_ready, oh);
        tick();
        req_valid = '0;
        lat = 1;
        n = 0;
        while (!rsp_valid && n < 50) begin tick(); lat++; n++; end
        check("op_rsp_seen", rsp_valid, 1'b1);
        p  = rsp_p;
        id = rsp_id;
        tick();
    endtask

    initial begin
        int          lat;
        int          id;
        int          ng;
        int          n;
        logic [127:0] p;
        int          gidx[6];
        int          gcyc[6];
        int          exp_order[6] = '{3, 0, 1, 2, 3, 0};
        logic [63:0] mx;
        mx = 64'hFFFF_FFFF_FFFF_FFFF;

        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", req_ready, 4'b0000);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_mul_a", mul_a, 64'd0);
        check("rst_rsp_p", rsp_p, 128'd0);
        check("rst_rsp_id", rsp_id, 2'd0);
        rst = 1'b0;
        tick();

        op(0, 64'd3, 64'd5, lat, p, id);
        check("single_lat", lat, 3);
        check("single_p", p, 128'd15);
        check("single_id", id, 0);

        op(1, mx, mx, lat, p, id);
        check("max_p", p, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
        check("max_id", id, 1);

        op(2, 64'd7, 64'd9, lat, p, id);
        check("sparse1_p", p, 128'd63);
        op(2, 64'h1_0000_0000, 64'h1_0000_0000, lat, p, id);
        check("sparse_wrap_p", p, 128'h1_0000_0000_0000_0000);
        check("sparse_wrap_id", id, 2);

        for (int i = 0; i < NREQ; i++) begin
            req_a[i*W +: W] = 64'(i + 2);
            req_b[i*W +: W] = 64'd10;
        end
        for (int k = 0; k < 6; k++) begin gidx[k] = -1; gcyc[k] = -1; end
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        #1;
        ng = 0;
        n  = 0;
        while (ng < 6 && n < 60) begin
            if (req_ready != '0) begin
                for (int i = 0; i < NREQ; i++) if (req_ready[i]) gidx[ng] = i;
                gcyc[ng] = n;
                ng++;
            end
            tick();
            n++;
        end
        check("rr_count", ng, 6);
        for (int k = 0; k < 6; k++) check($sformatf("rr_order%0d", k), gidx[k], exp_order[k]);
        for (int k = 1; k < 6; k++) check($sformatf("rr_gap%0d", k), gcyc[k] - gcyc[k-1], 4);

        rsp_ready = 1'b0;
        n = 0;
        while (!rsp_valid && n < 50) begin tick(); n++; end
        for (int k = 0; k < 10; k++) begin
            check("bp_valid", rsp_valid, 1'b1);
            check("bp_p", rsp_p, 128'd20);
            check("bp_id", rsp_id, 2'd0);
            check("bp_ready", req_ready, 4'b0000);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        check("bp_next_grant", req_ready, 4'b0010);

        tick();
        req_valid = '0;
        #1 rst = 1'b1;
        #1;
        check("midrst_rsp_valid", rsp_valid, 1'b0);
        check("midrst_mul_a", mul_a, 64'd0);
        check("midrst_mul_b", mul_b, 64'd0);
        check("midrst_rsp_p", rsp_p, 128'd0);
        check("midrst_req_ready", req_ready, 4'b0000);
        rst = 1'b0;
        req_valid = 4'b1111;
        #1;
        check("midrst_next_grant", req_ready, 4'b0001);
        tick();

        for (int c = 0; c < 6000; c++) begin
            req_valid = 4'($urandom);
            for (int i = 0; i < NREQ; i++) begin
                case ($urandom_range(0, 7))
                    0:       req_a[i*W +: W] = mx;
                    1:       req_a[i*W +: W] = 64'd0;
                    default: req_a[i*W +: W] = {$urandom, $urandom};
                endcase
                case ($urandom_range(0, 7))
                    0:       req_b[i*W +: W] = mx;
                    default: req_b[i*W +: W] = {$urandom, $urandom};
                endcase
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
